// File: rtl/cpu_trace_emitter_pkg.sv
// Shared definitions for the CPU trace emitter.
// Holds the ASCII constants of the trace character protocol, the emitter FSM
// state type, record-kind encodings and small field helpers.
package cpu_trace_emitter_pkg;

  // ASCII characters of the trace format
  localparam logic [7:0] ChCaret  = 8'h5E;  // '^'
  localparam logic [7:0] ChAt     = 8'h40;  // '@'
  localparam logic [7:0] ChColon  = 8'h3A;  // ':'
  localparam logic [7:0] ChDollar = 8'h24;  // '$'
  localparam logic [7:0] ChStar   = 8'h2A;  // '*'
  localparam logic [7:0] ChLt     = 8'h3C;  // '<'
  localparam logic [7:0] ChEq     = 8'h3D;  // '='
  localparam logic [7:0] ChHash   = 8'h23;  // '#'
  localparam logic [7:0] ChZero   = 8'h30;  // '0'
  localparam logic [7:0] ChLowerA = 8'h61;  // 'a'
  localparam logic [7:0] ChUpperA = 8'h41;  // 'A'

  // Record kinds
  localparam logic KindReg = 1'b0;
  localparam logic KindMem = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StCaret,
    StTime,
    StAt,
    StPc,
    StColon,
    StMark,
    StDest,
    StLt,
    StEq,
    StData,
    StHash
  } emit_state_e;

  // Selects nibble idx (0 = least significant) of a 32-bit word.
  function automatic logic [3:0] nib32(input logic [31:0] w, input logic [2:0] idx);
    return w[{idx, 2'b00} +: 4];
  endfunction

  // True when all four BCD digits are in 0..9.
  function automatic logic bcd_ok(input logic [15:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to ASCII hex digit.
// Ports:
//   nib   - input value 0..15
//   ascii - '0'..'9', then 'a'..'f' (or 'A'..'F' when HEX_UPPER = 1)
module nibble_to_ascii
  import cpu_trace_emitter_pkg::*;
#(
  parameter bit HEX_UPPER = 1'b0
) (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  localparam logic [7:0] LetterBase = HEX_UPPER ? ChUpperA : ChLowerA;

  always_comb begin
    if (nib < 4'd10) begin
      ascii = ChZero + {4'h0, nib};
    end else begin
      ascii = LetterBase + {4'h0, nib} - 8'd10;
    end
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// CPU write-back trace emitter.
// Captures one commit record per rec_valid/rec_ready handshake and serialises it
// into the ASCII trace stream, one character per char_valid/char_ready beat:
//   register write: ^<time>@<pc>:$<reg><=<data>#
//   memory write:   ^<time>@<pc>:*<addr><=<data>#
// Ports:
//   clk, reset                - clock, synchronous active-low reset
//   rec_valid/rec_ready       - record handshake (ready only while idle)
//   rec_kind                  - 0 register write, 1 memory write
//   rec_time                  - 4-digit BCD timestamp
//   rec_pc, rec_reg, rec_addr, rec_data - record fields
//   char_valid/char_ready     - character handshake
//   char                      - ASCII character (8'h00 when not valid)
//   bad_bcd                   - one-cycle pulse when a record is rejected for bad BCD
module cpu_trace_emitter
  import cpu_trace_emitter_pkg::*;
#(
  parameter bit HEX_UPPER      = 1'b0,
  parameter bit SUPPRESS_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rec_valid,
  output logic        rec_ready,
  input  logic        rec_kind,
  input  logic [15:0] rec_time,
  input  logic [31:0] rec_pc,
  input  logic [4:0]  rec_reg,
  input  logic [31:0] rec_addr,
  input  logic [31:0] rec_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char,
  output logic        bad_bcd
);

  emit_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        kind_q, kind_d;
  logic [15:0] time_q, time_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  reg_q, reg_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        bad_bcd_q, bad_bcd_d;

  logic        advance;
  logic [1:0]  tens;
  logic [4:0]  tens_sub;
  logic [3:0]  ones;
  logic [3:0]  digit_nib;
  logic [7:0]  digit_char;

  // Index of the first time digit to emit; leading zeros skipped when enabled,
  // but digit 0 is always emitted.
  function automatic logic [2:0] time_start(input logic [15:0] t);
    if (!SUPPRESS_ZEROS)       return 3'd3;
    else if (t[15:12] != 4'h0) return 3'd3;
    else if (t[11:8] != 4'h0)  return 3'd2;
    else if (t[7:4] != 4'h0)   return 3'd1;
    else                       return 3'd0;
  endfunction

  assign rec_ready  = (state_q == StIdle);
  assign char_valid = (state_q != StIdle);
  assign advance    = char_valid && char_ready;
  assign bad_bcd    = bad_bcd_q;

  // Decimal split of the register number by comparison, avoiding a divider.
  always_comb begin
    if (reg_q >= 5'd30) begin
      tens     = 2'd3;
      tens_sub = 5'd30;
    end else if (reg_q >= 5'd20) begin
      tens     = 2'd2;
      tens_sub = 5'd20;
    end else if (reg_q >= 5'd10) begin
      tens     = 2'd1;
      tens_sub = 5'd10;
    end else begin
      tens     = 2'd0;
      tens_sub = 5'd0;
    end
  end

  assign ones = 4'(reg_q - tens_sub);

  // Single digit path shared by every numeric field.
  always_comb begin
    digit_nib = 4'h0;
    unique case (state_q)
      StTime:  digit_nib = time_q[{cnt_q[1:0], 2'b00} +: 4];
      StPc:    digit_nib = nib32(pc_q, cnt_q);
      StDest: begin
        if (kind_q == KindMem) digit_nib = nib32(addr_q, cnt_q);
        else if (cnt_q[0])     digit_nib = {2'b00, tens};
        else                   digit_nib = ones;
      end
      StData:  digit_nib = nib32(data_q, cnt_q);
      default: digit_nib = 4'h0;
    endcase
  end

  nibble_to_ascii #(
    .HEX_UPPER(HEX_UPPER)
  ) u_nibble_to_ascii (
    .nib  (digit_nib),
    .ascii(digit_char)
  );

  always_comb begin
    char = 8'h00;
    unique case (state_q)
      StIdle:  char = 8'h00;
      StCaret: char = ChCaret;
      StTime,
      StPc,
      StDest,
      StData:  char = digit_char;
      StAt:    char = ChAt;
      StColon: char = ChColon;
      StMark:  char = (kind_q == KindMem) ? ChStar : ChDollar;
      StLt:    char = ChLt;
      StEq:    char = ChEq;
      StHash:  char = ChHash;
      default: char = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    time_d    = time_q;
    pc_d      = pc_q;
    reg_d     = reg_q;
    addr_d    = addr_q;
    data_d    = data_q;
    bad_bcd_d = 1'b0;

    if (state_q == StIdle) begin
      if (rec_valid) begin
        if (!bcd_ok(rec_time)) begin
          bad_bcd_d = 1'b1;
        end else begin
          kind_d  = rec_kind;
          time_d  = rec_time;
          pc_d    = rec_pc;
          reg_d   = rec_reg;
          addr_d  = rec_addr;
          data_d  = rec_data;
          state_d = StCaret;
        end
      end
    end else if (advance) begin
      unique case (state_q)
        StCaret: begin
          state_d = StTime;
          cnt_d   = time_start(time_q);
        end
        StTime: begin
          if (cnt_q == 3'd0) state_d = StAt;
          else               cnt_d = cnt_q - 3'd1;
        end
        StAt: begin
          state_d = StPc;
          cnt_d   = 3'd7;
        end
        StPc: begin
          if (cnt_q == 3'd0) state_d = StColon;
          else               cnt_d = cnt_q - 3'd1;
        end
        StColon: state_d = StMark;
        StMark: begin
          state_d = StDest;
          // Memory: 8 hex digits; register: 2 digits only from 10 upward.
          if (kind_q == KindMem)   cnt_d = 3'd7;
          else if (reg_q >= 5'd10) cnt_d = 3'd1;
          else                     cnt_d = 3'd0;
        end
        StDest: begin
          if (cnt_q == 3'd0) state_d = StLt;
          else               cnt_d = cnt_q - 3'd1;
        end
        StLt: state_d = StEq;
        StEq: begin
          state_d = StData;
          cnt_d   = 3'd7;
        end
        StData: begin
          if (cnt_q == 3'd0) state_d = StHash;
          else               cnt_d = cnt_q - 3'd1;
        end
        StHash:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      kind_q    <= KindReg;
      time_q    <= 16'h0000;
      pc_q      <= 32'h0;
      reg_q     <= 5'd0;
      addr_q    <= 32'h0;
      data_q    <= 32'h0;
      bad_bcd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      time_q    <= time_d;
      pc_q      <= pc_d;
      reg_q     <= reg_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bad_bcd_q <= bad_bcd_d;
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter. Two instances share all inputs:
//   dut_a - defaults (lower-case hex, leading time zeros suppressed)
//   dut_b - HEX_UPPER = 1, SUPPRESS_ZEROS = 0
// Expected characters are built by a bench-side model into one queue per instance
// when a record is offered and popped as beats are accepted.
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rec_valid;
  logic        rec_kind;
  logic [15:0] rec_time;
  logic [31:0] rec_pc;
  logic [4:0]  rec_reg;
  logic [31:0] rec_addr;
  logic [31:0] rec_data;
  logic        char_ready;

  logic        rec_ready_a, char_valid_a, bad_bcd_a;
  logic [7:0]  ch_a;
  logic        rec_ready_b, char_valid_b, bad_bcd_b;
  logic [7:0]  ch_b;

  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_trace_emitter dut_a (
    .clk       (clk),
    .reset     (reset),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready_a),
    .rec_kind  (rec_kind),
    .rec_time  (rec_time),
    .rec_pc    (rec_pc),
    .rec_reg   (rec_reg),
    .rec_addr  (rec_addr),
    .rec_data  (rec_data),
    .char_valid(char_valid_a),
    .char_ready(char_ready),
    .char      (ch_a),
    .bad_bcd   (bad_bcd_a)
  );

  cpu_trace_emitter #(
    .HEX_UPPER     (1'b1),
    .SUPPRESS_ZEROS(1'b0)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready_b),
    .rec_kind  (rec_kind),
    .rec_time  (rec_time),
    .rec_pc    (rec_pc),
    .rec_reg   (rec_reg),
    .rec_addr  (rec_addr),
    .rec_data  (rec_data),
    .char_valid(char_valid_b),
    .char_ready(char_ready),
    .char      (ch_b),
    .bad_bcd   (bad_bcd_b)
  );

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit upper);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (upper ? 8'h41 : 8'h61) + 8'(n) - 8'd10;
  endfunction

  task automatic push(input int which, input logic [7:0] c);
    if (which == 0) q_a.push_back(c);
    else            q_b.push_back(c);
  endtask

  // Reference model of one trace line.
  task automatic expect_record(input int which, input bit kind, input logic [15:0] t,
                               input logic [31:0] pc, input logic [4:0] rg,
                               input logic [31:0] addr, input logic [31:0] data,
                               input bit upper, input bit supp);
    int first;
    push(which, "^");
    first = 3;
    if (supp) while (first > 0 && t[first*4 +: 4] == 4'h0) first--;
    for (int i = first; i >= 0; i--) push(which, hexc(t[i*4 +: 4], upper));
    push(which, "@");
    for (int i = 7; i >= 0; i--) push(which, hexc(pc[i*4 +: 4], upper));
    push(which, ":");
    if (kind) begin
      push(which, "*");
      for (int i = 7; i >= 0; i--) push(which, hexc(addr[i*4 +: 4], upper));
    end else begin
      push(which, "$");
      if (rg >= 5'd10) push(which, 8'h30 + 8'(rg / 5'd10));
      push(which, 8'h30 + 8'(rg % 5'd10));
    end
    push(which, "<");
    push(which, "=");
    for (int i = 7; i >= 0; i--) push(which, hexc(data[i*4 +: 4], upper));
    push(which, "#");
  endtask

  task automatic send_record(input bit kind, input logic [15:0] t, input logic [31:0] pc,
                             input logic [4:0] rg, input logic [31:0] addr,
                             input logic [31:0] data);
    @(negedge clk);
    checks++;
    if (rec_ready_a !== 1'b1 || rec_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: rec_ready a=%b b=%b, want 1", rec_ready_a, rec_ready_b);
    end
    rec_kind  = kind;
    rec_time  = t;
    rec_pc    = pc;
    rec_reg   = rg;
    rec_addr  = addr;
    rec_data  = data;
    rec_valid = 1'b1;
    expect_record(0, kind, t, pc, rg, addr, data, 1'b0, 1'b1);
    expect_record(1, kind, t, pc, rg, addr, data, 1'b1, 1'b0);
    @(posedge clk);
    #1 rec_valid = 1'b0;
  endtask

  // Consumes both streams. Each beat is compared against the model; a stalled
  // char must hold; the cycle after '#' must be idle and ready.
  task automatic drain(input string name, input bit random_ready);
    bit         st_a = 1'b0, st_b = 1'b0, fin_a = 1'b0, fin_b = 1'b0;
    logic [7:0] prev_a = 8'h00, prev_b = 8'h00, exp;
    int         cyc = 0;
    while (cyc < 600 && (q_a.size() != 0 || q_b.size() != 0 || fin_a || fin_b)) begin
      cyc++;
      @(negedge clk);
      char_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      // instance a
      if (fin_a) begin
        checks++;
        if (char_valid_a !== 1'b0 || rec_ready_a !== 1'b1) begin
          errors++;
          $display("FAIL %s idle_after_hash_a: valid=%b ready=%b, want valid=0 ready=1",
                   name, char_valid_a, rec_ready_a);
        end
        fin_a = 1'b0;
      end else if (q_a.size() != 0) begin
        if (st_a) begin
          checks++;
          if (ch_a !== prev_a) begin
            errors++;
            $display("FAIL %s stall_hold_a: char=%h, want %h", name, ch_a, prev_a);
          end
        end
        checks++;
        if (char_valid_a !== 1'b1 || rec_ready_a !== 1'b0) begin
          errors++;
          $display("FAIL %s stream_a: valid=%b ready=%b, want valid=1 ready=0",
                   name, char_valid_a, rec_ready_a);
        end else if (char_ready) begin
          exp = q_a.pop_front();
          checks++;
          if (ch_a !== exp) begin
            errors++;
            $display("FAIL %s char_a: got '%c' (%h), want '%c' (%h)", name, ch_a, ch_a, exp, exp);
          end
          st_a = 1'b0;
          if (q_a.size() == 0) fin_a = 1'b1;
        end else begin
          st_a   = 1'b1;
          prev_a = ch_a;
        end
      end else begin
        checks++;
        if (char_valid_a !== 1'b0 || ch_a !== 8'h00) begin
          errors++;
          $display("FAIL %s extra_a: valid=%b char=%h, want valid=0 char=00",
                   name, char_valid_a, ch_a);
        end
      end
      // instance b
      if (fin_b) begin
        checks++;
        if (char_valid_b !== 1'b0 || rec_ready_b !== 1'b1) begin
          errors++;
          $display("FAIL %s idle_after_hash_b: valid=%b ready=%b, want valid=0 ready=1",
                   name, char_valid_b, rec_ready_b);
        end
        fin_b = 1'b0;
      end else if (q_b.size() != 0) begin
        if (st_b) begin
          checks++;
          if (ch_b !== prev_b) begin
            errors++;
            $display("FAIL %s stall_hold_b: char=%h, want %h", name, ch_b, prev_b);
          end
        end
        checks++;
        if (char_valid_b !== 1'b1 || rec_ready_b !== 1'b0) begin
          errors++;
          $display("FAIL %s stream_b: valid=%b ready=%b, want valid=1 ready=0",
                   name, char_valid_b, rec_ready_b);
        end else if (char_ready) begin
          exp = q_b.pop_front();
          checks++;
          if (ch_b !== exp) begin
            errors++;
            $display("FAIL %s char_b: got '%c' (%h), want '%c' (%h)", name, ch_b, ch_b, exp, exp);
          end
          st_b = 1'b0;
          if (q_b.size() == 0) fin_b = 1'b1;
        end else begin
          st_b   = 1'b1;
          prev_b = ch_b;
        end
      end else begin
        checks++;
        if (char_valid_b !== 1'b0 || ch_b !== 8'h00) begin
          errors++;
          $display("FAIL %s extra_b: valid=%b char=%h, want valid=0 char=00",
                   name, char_valid_b, ch_b);
        end
      end
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: left a=%0d b=%0d chars, want 0", name, q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
    char_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    rec_valid  = 1'b0;
    rec_kind   = 1'b0;
    rec_time   = 16'h0;
    rec_pc     = 32'h0;
    rec_reg    = 5'd0;
    rec_addr   = 32'h0;
    rec_data   = 32'h0;
    char_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rec_ready_a !== 1'b1 || char_valid_a !== 1'b0 || ch_a !== 8'h00 || bad_bcd_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: ready=%b valid=%b char=%h bad=%b, want 1 0 00 0",
               rec_ready_a, char_valid_a, ch_a, bad_bcd_a);
    end
    checks++;
    if (rec_ready_b !== 1'b1 || char_valid_b !== 1'b0 || ch_b !== 8'h00 || bad_bcd_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: ready=%b valid=%b char=%h bad=%b, want 1 0 00 0",
               rec_ready_b, char_valid_b, ch_b, bad_bcd_b);
    end
    reset = 1'b1;
  endtask

  task automatic test_reg_record();
    send_record(1'b0, 16'h0006, 32'h12345678, 5'd4, 32'h0, 32'h000030f4);
    drain("reg_record", 1'b0);
  endtask

  task automatic test_mem_record();
    send_record(1'b1, 16'h0120, 32'h00003000, 5'd0, 32'h0000abcd, 32'hdeadbeef);
    drain("mem_record", 1'b0);
  endtask

  task automatic test_boundaries();
    send_record(1'b0, 16'h0000, 32'h00000040, 5'd31, 32'h0, 32'h00000001);
    drain("time0_reg31", 1'b0);
    send_record(1'b0, 16'h9999, 32'hffffffff, 5'd0, 32'h0, 32'ha5a5c3c3);
    drain("time9999_reg0", 1'b0);
    send_record(1'b0, 16'h0100, 32'h0badf00d, 5'd10, 32'h0, 32'h0);
    drain("time0100_reg10", 1'b0);
  endtask

  task automatic test_back_to_back();
    send_record(1'b0, 16'h0042, 32'h00001000, 5'd19, 32'h0, 32'h12121212);
    drain("b2b_first", 1'b0);
    send_record(1'b1, 16'h1000, 32'h00001004, 5'd0, 32'hfedcba98, 32'h76543210);
    drain("b2b_second", 1'b0);
  endtask

  task automatic test_backpressure();
    send_record(1'b0, 16'h0006, 32'h12345678, 5'd4, 32'h0, 32'h000030f4);
    drain("backpressure_reg", 1'b1);
    send_record(1'b1, 16'h0120, 32'h00003000, 5'd0, 32'h0000abcd, 32'hdeadbeef);
    drain("backpressure_mem", 1'b1);
  endtask

  task automatic test_bad_bcd();
    logic [15:0] bad_times[2];
    bad_times[0] = 16'h00a1;
    bad_times[1] = 16'hf000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rec_kind  = 1'b0;
      rec_time  = bad_times[i];
      rec_pc    = 32'h1;
      rec_reg   = 5'd1;
      rec_data  = 32'h2;
      rec_valid = 1'b1;
      @(posedge clk);
      #1 rec_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bad_bcd_a !== 1'b1 || char_valid_a !== 1'b0 || rec_ready_a !== 1'b1 ||
          bad_bcd_b !== 1'b1 || char_valid_b !== 1'b0 || rec_ready_b !== 1'b1) begin
        errors++;
        $display("FAIL bad_bcd_pulse %h: bad=%b/%b valid=%b/%b ready=%b/%b, want 1 0 1",
                 bad_times[i], bad_bcd_a, bad_bcd_b, char_valid_a, char_valid_b,
                 rec_ready_a, rec_ready_b);
      end
      @(negedge clk);
      checks++;
      if (bad_bcd_a !== 1'b0 || char_valid_a !== 1'b0 ||
          bad_bcd_b !== 1'b0 || char_valid_b !== 1'b0) begin
        errors++;
        $display("FAIL bad_bcd_single %h: bad=%b/%b valid=%b/%b, want 0 0",
                 bad_times[i], bad_bcd_a, bad_bcd_b, char_valid_a, char_valid_b);
      end
    end
    send_record(1'b0, 16'h0021, 32'h00000100, 5'd7, 32'h0, 32'hcafef00d);
    drain("after_bad_bcd", 1'b0);
  endtask

  task automatic test_reset_mid_record();
    send_record(1'b0, 16'h0006, 32'h12345678, 5'd4, 32'h0, 32'h000030f4);
    char_ready = 1'b1;
    // '^','6','@' accepted, fourth beat is the first PC digit of instance a
    repeat (4) @(negedge clk);
    checks++;
    if (ch_a !== "1" || char_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_record_pos: valid=%b char=%h, want valid=1 char=31", char_valid_a, ch_a);
    end
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (char_valid_a !== 1'b0 || ch_a !== 8'h00 || rec_ready_a !== 1'b1 ||
        char_valid_b !== 1'b0 || ch_b !== 8'h00 || rec_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort: valid=%b/%b char=%h/%h ready=%b/%b, want 0 00 1",
               char_valid_a, char_valid_b, ch_a, ch_b, rec_ready_a, rec_ready_b);
    end
    q_a.delete();
    q_b.delete();
    send_record(1'b1, 16'h0305, 32'h80000000, 5'd0, 32'h0000000f, 32'h00000000);
    drain("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_reg_record();
    test_mem_record();
    test_boundaries();
    test_back_to_back();
    test_backpressure();
    test_bad_bcd();
    test_reset_mid_record();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
